mult_err_sweep: RTL and testbench
=================================

Name: mult_err_sweep

Overview:
- Exhaustive error-characterisation engine for the 8x8 approximate multipliers (N/R-type 4x4 compositions with OR/adder reduction).
- Drives every operand pair into a multiplier under test, takes its 16-bit product back, and compares it with the exact product.
- Accumulates error count, sum of error distance (ED) and maximum ED, plus the operands of the worst case.
- Sits beside a multiplier instance in characterisation builds, so each library variant is scored in hardware.

Parameters:
- W, 8, operand width. Fixed at 8; product is 2W = 16.
- LAT, 0, pipeline latency of the multiplier under test, 0..3. 0 means approx_r is combinational from op_a/op_b in the same cycle.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin sweep; sampled only in IDLE
- op_a  out  8  operand A to multiplier
- op_b  out  8  operand B to multiplier
- approx_r  in  16  product returned by multiplier
- busy  out  1  high from the cycle after start is accepted through the DRAIN state
- done  out  1  one-cycle pulse; results final
- err_cnt  out  17  number of pairs with ED != 0
- sum_ed  out  32  sum of ED over all pairs
- max_ed  out  16  largest ED
- worst_a  out  8  op_a of first pair reaching max_ed
- worst_b  out  8  op_b of first pair reaching max_ed

Behaviour:
- Reset (synchronous, highest priority, also mid-sweep):
  - State goes to IDLE.
  - All outputs are 0, including op_a, op_b, busy, done, all accumulators and worst_a/b.
  - The latency pipeline valid bits are cleared.
- States:
  - IDLE: start=1 moves to SWEEP. Clear the accumulators, index cnt = 0.
  - SWEEP: each cycle drive op_a = cnt[7:0] and op_b = cnt[15:8], then cnt++. After cnt = 16'hFFFF is driven, go to DRAIN (LAT>0) or DONE (LAT=0).
  - DRAIN: stay exactly LAT cycles; operands hold at 0, no new valid pair issued.
  - DONE: done=1 for one cycle, busy=0, then go to IDLE.
- start while not IDLE is ignored.
- Results hold until the next accepted start or rst.
- op_a/op_b are registered and return to 0 outside SWEEP.
- Alignment:
  - Exact product a*b (16 bits), the operands and a valid bit pass through a LAT-deep shift register.
  - The stage leaving the shift register is compared with approx_r sampled in that same cycle.
  - For LAT=0, the compare uses the currently driven operands.
- Arithmetic per valid pair:
  - ED = |approx_r - exact|, computed in 17-bit signed and stored as 16-bit magnitude (max 65535).
  - err_cnt += (ED != 0).
  - sum_ed += ED. 32 bits cannot overflow: max 65536*65535.
  - If ED > max_ed (strict), update max_ed, worst_a and worst_b. Ties keep the earlier pair in sweep order.
- Timing: with start accepted at edge k, pair i is driven in cycle k+1+i.
  - Last accumulation happens at the edge ending cycle k+65536+LAT.
  - done is high in cycle k+65537+LAT.
  - busy is high for 65536+LAT cycles.
- Accumulation never occurs in IDLE/DONE, even if approx_r toggles.

Test Plan:
- Exact model (approx_r = op_a*op_b), LAT=0, start at cycle 0:
  - err_cnt=0, sum_ed=0, max_ed=0, worst_a=worst_b=0.
  - done pulse in cycle 65537; busy high 65536 cycles.
- Model approx_r = (a*b)|1:
  - Even products err: err_cnt=49152, sum_ed=49152, max_ed=1.
  - worst_a=0, worst_b=0 (first pair; tie rule).
- Model approx_r = 0:
  - err_cnt=65025, sum_ed=1065369600 (32640^2), max_ed=65025, worst_a=255, worst_b=255.
- LAT=2 with a two-stage registered exact model:
  - Same results as the first scenario.
  - done in cycle 65539.
  - Same model with LAT=0 (misaligned): err_cnt != 0, which proves the alignment is exercised.
- Assert rst at cycle 1000 of a sweep:
  - Next cycle busy=0, op_a=op_b=0, all accumulators 0, no done.
  - A fresh start gives the full results of the first scenario.
- Pulse start at cycles 5 and 40000 during a sweep:
  - Both are ignored; a single done at cycle 65537.
  - After done, a second start clears the results from the previous run before accumulating again.

Source files
------------

// File: rtl/mult_err_sweep.sv
// mult_err_sweep: error-characterisation engine for an 8x8 approximate multiplier.
// It drives every operand pair (op_a = index[7:0], op_b = index[15:8]) into the
// multiplier under test. Each returned product is compared with the exact product,
// delayed by the multiplier's pipeline latency LAT. The block accumulates error
// count, sum of error distance, maximum error distance, and the first operand
// pair that reached that maximum.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a sweep (only honoured in IDLE)
//   op_a, op_b        registered operands to the multiplier under test
//   approx_r          product returned by the multiplier under test
//   busy              high while sweeping and draining the latency pipeline
//   done              one-cycle pulse when the results are final
//   err_cnt           number of pairs whose product was wrong
//   sum_ed            sum of |approx - exact| over all pairs
//   max_ed            largest |approx - exact|
//   worst_a, worst_b  operands of the first pair that reached max_ed
module mult_err_sweep #(
  parameter int W   = 8,
  parameter int LAT = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [W-1:0]   op_a,
  output logic [W-1:0]   op_b,
  input  logic [2*W-1:0] approx_r,
  output logic           busy,
  output logic           done,
  output logic [2*W:0]   err_cnt,
  output logic [31:0]    sum_ed,
  output logic [2*W-1:0] max_ed,
  output logic [W-1:0]   worst_a,
  output logic [W-1:0]   worst_b
);

  localparam int PW = 2 * W;
  localparam logic [1:0] DRAIN_LAST = (LAT > 0) ? 2'(LAT - 1) : 2'd0;

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_FIN} state_t;

  // One in-flight pair: valid flag, operands and the exact reference product.
  typedef struct packed {
    logic          v;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [PW-1:0] p;
  } stage_t;

  state_t        state, state_nx;
  logic [PW-1:0] cnt;
  logic [1:0]    drain_cnt;
  logic          start_acc;
  logic          acc_en;
  stage_t        stg_in, stg_out;
  logic [PW:0]   diff;
  logic [PW:0]   mag;
  logic [PW-1:0] ed;

  assign start_acc = (state == S_IDLE) && start;

  // The operand outputs are the index register itself. This keeps them
  // registered and makes them return to zero whenever the index is cleared.
  assign op_a = cnt[W-1:0];
  assign op_b = cnt[PW-1:W];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and infers a latch.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_SWEEP;
      end
      S_SWEEP: begin
        busy = 1'b1;
        if (cnt == '1) state_nx = (LAT > 0) ? S_DRAIN : S_FIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == DRAIN_LAST) state_nx = S_FIN;
      end
      S_FIN: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Sweep index. It wraps from FFFF to 0 at the moment the sweep leaves
  // SWEEP, so the operands are already zero in DRAIN and DONE.
  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (state == S_SWEEP) cnt <= cnt + 1'b1;
    else                       cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (rst)                   drain_cnt <= '0;
    else if (state == S_DRAIN) drain_cnt <= drain_cnt + 1'b1;
    else                       drain_cnt <= '0;
  end

  always_comb begin
    stg_in.v = (state == S_SWEEP);
    stg_in.a = op_a;
    stg_in.b = op_b;
    stg_in.p = PW'(op_a) * PW'(op_b);
  end

  // The reference path is delayed LAT cycles. Its output stage therefore
  // lines up with the approx_r value that the multiplier returns for the same
  // operands.
  if (LAT == 0) begin : g_comb
    assign stg_out = stg_in;
  end else begin : g_pipe
    stage_t pipe [LAT];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < LAT; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= stg_in;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign stg_out = pipe[LAT-1];
  end

  // Error distance: take the 17-bit two's-complement difference of the
  // zero-extended products, then its magnitude. The magnitude always fits
  // in 16 bits.
  always_comb begin
    diff = {1'b0, approx_r} - {1'b0, stg_out.p};
    mag  = diff[PW] ? -diff : diff;
    ed   = mag[PW-1:0];
  end

  // The valid bit only comes from SWEEP. The state gate still blocks any
  // accumulation in IDLE or DONE.
  assign acc_en = stg_out.v && ((state == S_SWEEP) || (state == S_DRAIN));

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      err_cnt <= '0;
      sum_ed  <= '0;
      max_ed  <= '0;
      worst_a <= '0;
      worst_b <= '0;
    end else if (acc_en) begin
      err_cnt <= err_cnt + {{PW{1'b0}}, (ed != '0)};
      sum_ed  <= sum_ed + 32'(ed);
      // Strict compare: on a tie the earlier pair in sweep order is kept.
      if (ed > max_ed) begin
        max_ed  <= ed;
        worst_a <= stg_out.a;
        worst_b <= stg_out.b;
      end
    end
  end

endmodule

// File: tb/tb_mult_err_sweep.sv
// Testbench for mult_err_sweep. Six instances run side by side, each with its
// own multiplier model:
//   u0  exact product, LAT=0; extra start pulses during the sweep
//   u1  exact product with bit 0 forced high; restarted after done
//   u2  constant zero product
//   u3  two-stage registered exact model, LAT=2
//   u4  the same registered model with LAT=0 (misaligned on purpose)
//   u5  zero model, reset mid-sweep, then restarted with the exact model
// Expected end-of-sweep results are queued when each start is issued. A
// monitor pops and compares them whenever an instance pulses done.
module tb_mult_err_sweep;

  localparam int N = 6;
  localparam int S = 5;

  typedef struct {
    logic [16:0] err;
    logic [31:0] sum;
    logic [15:0] max;
    logic [7:0]  wa;
    logic [7:0]  wb;
    int          done_cyc;
    int          busy_n;
    bit          nz_only;
  } exp_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  logic [N-1:0] rst_v;
  logic [N-1:0] start_v;
  logic [7:0]  op_a    [N];
  logic [7:0]  op_b    [N];
  logic [15:0] approx  [N];
  logic        busy    [N];
  logic        done    [N];
  logic [16:0] err_cnt [N];
  logic [31:0] sum_ed  [N];
  logic [15:0] max_ed  [N];
  logic [7:0]  worst_a [N];
  logic [7:0]  worst_b [N];

  logic [15:0] m3_1 = '0, m3_2 = '0, m4_1 = '0, m4_2 = '0;
  logic        mode5 = 1'b0;

  exp_t exp_q [N][$];
  int   busy_n [N];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier models.
  assign approx[0] = {8'd0, op_a[0]} * {8'd0, op_b[0]};
  assign approx[1] = ({8'd0, op_a[1]} * {8'd0, op_b[1]}) | 16'd1;
  assign approx[2] = 16'd0;
  assign approx[3] = m3_2;
  assign approx[4] = m4_2;
  assign approx[5] = mode5 ? {8'd0, op_a[5]} * {8'd0, op_b[5]} : 16'd0;

  always @(posedge clk) begin
    m3_1 <= {8'd0, op_a[3]} * {8'd0, op_b[3]};
    m3_2 <= m3_1;
    m4_1 <= {8'd0, op_a[4]} * {8'd0, op_b[4]};
    m4_2 <= m4_1;
  end

  mult_err_sweep #(.W(8), .LAT(0)) u0 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .op_a(op_a[0]), .op_b(op_b[0]),
    .approx_r(approx[0]), .busy(busy[0]), .done(done[0]), .err_cnt(err_cnt[0]),
    .sum_ed(sum_ed[0]), .max_ed(max_ed[0]), .worst_a(worst_a[0]), .worst_b(worst_b[0]));
  mult_err_sweep #(.W(8), .LAT(0)) u1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .op_a(op_a[1]), .op_b(op_b[1]),
    .approx_r(approx[1]), .busy(busy[1]), .done(done[1]), .err_cnt(err_cnt[1]),
    .sum_ed(sum_ed[1]), .max_ed(max_ed[1]), .worst_a(worst_a[1]), .worst_b(worst_b[1]));
  mult_err_sweep #(.W(8), .LAT(0)) u2 (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .op_a(op_a[2]), .op_b(op_b[2]),
    .approx_r(approx[2]), .busy(busy[2]), .done(done[2]), .err_cnt(err_cnt[2]),
    .sum_ed(sum_ed[2]), .max_ed(max_ed[2]), .worst_a(worst_a[2]), .worst_b(worst_b[2]));
  mult_err_sweep #(.W(8), .LAT(2)) u3 (
    .clk(clk), .rst(rst_v[3]), .start(start_v[3]), .op_a(op_a[3]), .op_b(op_b[3]),
    .approx_r(approx[3]), .busy(busy[3]), .done(done[3]), .err_cnt(err_cnt[3]),
    .sum_ed(sum_ed[3]), .max_ed(max_ed[3]), .worst_a(worst_a[3]), .worst_b(worst_b[3]));
  mult_err_sweep #(.W(8), .LAT(0)) u4 (
    .clk(clk), .rst(rst_v[4]), .start(start_v[4]), .op_a(op_a[4]), .op_b(op_b[4]),
    .approx_r(approx[4]), .busy(busy[4]), .done(done[4]), .err_cnt(err_cnt[4]),
    .sum_ed(sum_ed[4]), .max_ed(max_ed[4]), .worst_a(worst_a[4]), .worst_b(worst_b[4]));
  mult_err_sweep #(.W(8), .LAT(0)) u5 (
    .clk(clk), .rst(rst_v[5]), .start(start_v[5]), .op_a(op_a[5]), .op_b(op_b[5]),
    .approx_r(approx[5]), .busy(busy[5]), .done(done[5]), .err_cnt(err_cnt[5]),
    .sum_ed(sum_ed[5]), .max_ed(max_ed[5]), .worst_a(worst_a[5]), .worst_b(worst_b[5]));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [16:0] err, input logic [31:0] sum,
                              input logic [15:0] max, input logic [7:0] wa,
                              input logic [7:0] wb, input int done_cyc,
                              input int busy_cnt, input bit nz_only);
    exp_t e;
    e.err = err; e.sum = sum; e.max = max; e.wa = wa; e.wb = wb;
    e.done_cyc = done_cyc; e.busy_n = busy_cnt; e.nz_only = nz_only;
    return e;
  endfunction

  // Advance to the falling edge inside cycle n (cyc == n there).
  task automatic to_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: on every falling edge, count busy cycles, and score each done pulse.
  initial begin
    exp_t e;
    for (int i = 0; i < N; i++) busy_n[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (busy[i] === 1'b1) busy_n[i]++;
        if (rst_v[i]) busy_n[i] = 0;
        if (done[i] === 1'b1) begin
          if (exp_q[i].size() == 0) begin
            check($sformatf("u%0d_spurious_done", i), done[i], 0);
          end else begin
            e = exp_q[i].pop_front();
            check($sformatf("u%0d_done_cycle", i), cyc, e.done_cyc);
            check($sformatf("u%0d_busy_at_done", i), busy[i], 0);
            check($sformatf("u%0d_busy_cycles", i), busy_n[i], e.busy_n);
            if (e.nz_only) begin
              check($sformatf("u%0d_err_nonzero", i), err_cnt[i] != 0, 1);
            end else begin
              check($sformatf("u%0d_err_cnt", i), err_cnt[i], e.err);
              check($sformatf("u%0d_sum_ed", i), sum_ed[i], e.sum);
              check($sformatf("u%0d_max_ed", i), max_ed[i], e.max);
              check($sformatf("u%0d_worst_a", i), worst_a[i], e.wa);
              check($sformatf("u%0d_worst_b", i), worst_b[i], e.wb);
            end
          end
          busy_n[i] = 0;
        end
      end
    end
  end

  initial begin
    rst_v   = '1;
    start_v = '0;
    @(negedge clk);
    to_cyc(3);
    rst_v = '0;
    to_cyc(4);
    for (int i = 0; i < N; i++) begin
      check($sformatf("u%0d_reset_busy", i), busy[i], 0);
      check($sformatf("u%0d_reset_ops", i), {op_b[i], op_a[i]}, 0);
      check($sformatf("u%0d_reset_err", i), err_cnt[i], 0);
    end

    // All instances start together in cycle S.
    to_cyc(S);
    start_v = '1;
    exp_q[0].push_back(mk(0, 0, 0, 0, 0, S + 65537, 65536, 0));
    exp_q[1].push_back(mk(49152, 49152, 1, 0, 0, S + 65537, 65536, 0));
    exp_q[2].push_back(mk(65025, 32'd1065369600, 16'd65025, 255, 255, S + 65537, 65536, 0));
    exp_q[3].push_back(mk(0, 0, 0, 0, 0, S + 65539, 65538, 0));
    exp_q[4].push_back(mk(0, 0, 0, 0, 0, S + 65537, 65536, 1));
    to_cyc(S + 1);
    start_v = '0;
    check("u0_busy_after_start", busy[0], 1);
    check("u0_first_pair", {op_b[0], op_a[0]}, 0);
    to_cyc(S + 2);
    check("u0_second_pair", {op_b[0], op_a[0]}, 1);

    // Start pulse during the sweep must be ignored.
    to_cyc(S + 5);
    start_v[0] = 1'b1;
    to_cyc(S + 6);
    start_v[0] = 1'b0;

    // Reset mid-sweep on u5 (zero model, so its accumulators are non-zero).
    to_cyc(S + 999);
    check("u5_busy_before_rst", busy[5], 1);
    check("u5_err_nonzero_before_rst", err_cnt[5] != 0, 1);
    to_cyc(S + 1000);
    rst_v[5] = 1'b1;
    to_cyc(S + 1001);
    rst_v[5] = 1'b0;
    check("u5_rst_busy", busy[5], 0);
    check("u5_rst_done", done[5], 0);
    check("u5_rst_ops", {op_b[5], op_a[5]}, 0);
    check("u5_rst_err", err_cnt[5], 0);
    check("u5_rst_sum", sum_ed[5], 0);
    check("u5_rst_max", max_ed[5], 0);
    check("u5_rst_worst", {worst_b[5], worst_a[5]}, 0);
    mode5 = 1'b1;
    to_cyc(S + 1002);
    check("u5_idle_after_rst", busy[5], 0);
    to_cyc(S + 1003);
    start_v[5] = 1'b1;
    exp_q[5].push_back(mk(0, 0, 0, 0, 0, S + 1003 + 65537, 65536, 0));
    to_cyc(S + 1004);
    start_v[5] = 1'b0;

    // Second ignored start pulse on u0.
    to_cyc(S + 40000);
    start_v[0] = 1'b1;
    to_cyc(S + 40001);
    start_v[0] = 1'b0;

    // u1: results hold through DONE/IDLE although the model returns 1 there.
    // A new start must then clear the results before it accumulates again.
    to_cyc(S + 65540);
    check("u1_hold_err", err_cnt[1], 49152);
    check("u1_hold_sum", sum_ed[1], 49152);
    start_v[1] = 1'b1;
    to_cyc(S + 65541);
    start_v[1] = 1'b0;
    check("u1_restart_busy", busy[1], 1);
    check("u1_restart_err", err_cnt[1], 0);
    check("u1_restart_sum", sum_ed[1], 0);
    check("u1_restart_max", max_ed[1], 0);
    to_cyc(S + 65542);
    check("u1_restart_err_1", err_cnt[1], 1);
    check("u1_restart_max_1", max_ed[1], 1);
    rst_v[1] = 1'b1;
    to_cyc(S + 65543);
    rst_v[1] = 1'b0;

    to_cyc(S + 66560);
    check("u2_hold_err", err_cnt[2], 65025);
    check("u2_hold_worst", {worst_b[2], worst_a[2]}, 16'hFFFF);
    for (int i = 0; i < N; i++)
      check($sformatf("u%0d_missing_done", i), exp_q[i].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
